// File: rtl/hdmi_rx_capture.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_rx_capture
// Purpose  : Captures 16-bit YCbCr 4:2:2 parallel video from an HDMI receiver
//            and emits it as an AXI4-Stream video. tuser marks the first pixel
//            of a frame and tlast marks the last pixel of a line. The block
//            also measures the active geometry and reports when it is stable.
// Ports    : clk, reset (async, active-high), enable (acted on at vsync edge)
//            hdmi_data/hdmi_data_e/hdmi_hsync/hdmi_vsync : receiver pins
//            m_axis_tdata/tvalid/tready/tuser/tlast      : video stream
//            width/height : geometry of the last complete frame
//            locked       : two consecutive equal, nonzero geometry captures
//            overflow     : sticky FIFO-full drop flag
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_rx_capture #(
  parameter int FIFO_DEPTH = 16,
  parameter int HS_POL     = 1,
  parameter int VS_POL     = 1,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [15:0]      hdmi_data,
  input  logic             hdmi_data_e,
  input  logic             hdmi_hsync,
  input  logic             hdmi_vsync,
  output logic [15:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] height,
  output logic             locked,
  output logic             overflow
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_ACTIVE = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  // ---------------- input stage ----------------
  logic [15:0] data_in_q;
  logic        de_in_q, vs_in_q, vs_prev_q;
  // Line structure is taken from DE alone; the normalised hsync is kept only
  // so the input stage is complete for debug probing.
  logic        hs_norm_unused_q;
  logic        vs_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_in_q        <= '0;
      de_in_q          <= 1'b0;
      vs_in_q          <= 1'b0;
      vs_prev_q        <= 1'b0;
      hs_norm_unused_q <= 1'b0;
    end else begin
      data_in_q        <= hdmi_data;
      de_in_q          <= hdmi_data_e;
      vs_in_q          <= (VS_POL != 0) ? hdmi_vsync : ~hdmi_vsync;
      vs_prev_q        <= vs_in_q;
      hs_norm_unused_q <= (HS_POL != 0) ? hdmi_hsync : ~hdmi_hsync;
    end
  end

  assign vs_edge = vs_in_q & ~vs_prev_q;

  // ---------------- pixel hold stage ----------------
  // A pixel waits here one cycle so that the DE of its successor (now in the
  // input stage) tells us whether it closes the line.
  logic [15:0] hold_data_q;
  logic        hold_vld_q, hold_user_q, sof_pend_q;
  logic        de_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data_q <= '0;
      hold_vld_q  <= 1'b0;
      hold_user_q <= 1'b0;
      sof_pend_q  <= 1'b0;
    end else begin
      hold_data_q <= data_in_q;
      hold_vld_q  <= de_in_q;
      hold_user_q <= de_in_q & sof_pend_q;
      sof_pend_q  <= vs_edge | (sof_pend_q & ~de_in_q);
    end
  end

  // hold_vld_q is the previous cycle's DE, so this is the DE falling edge.
  assign de_fall = hold_vld_q & ~de_in_q;

  // ---------------- FIFO pointers ----------------
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [17:0]  mem_q [FIFO_DEPTH];
  logic [17:0]  rd_word;
  logic         fifo_full, fifo_empty, push, pop, drop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = ~fifo_empty & m_axis_tready;

  // ---------------- capture FSM ----------------
  state_t state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_SEARCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      S_SEARCH: begin
        if (vs_edge && enable) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (hold_vld_q) begin
          if (fifo_full) begin
            drop    = 1'b1;
            state_d = S_DROP;
          end else begin
            push = 1'b1;
          end
        end
        // A new frame boundary overrides a drop in the same cycle.
        if (vs_edge) state_d = enable ? S_ACTIVE : S_SEARCH;
      end
      S_DROP: begin
        if (vs_edge) state_d = enable ? S_ACTIVE : S_SEARCH;
      end
      default: state_d = S_SEARCH;
    endcase
  end

  // ---------------- FIFO storage ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {hold_user_q, ~de_in_q, hold_data_q};
  end

  assign rd_word       = mem_q[rd_ptr_q[AW-1:0]];
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? 16'h0 : rd_word[15:0];
  assign m_axis_tlast  = fifo_empty ? 1'b0  : rd_word[16];
  assign m_axis_tuser  = fifo_empty ? 1'b0  : rd_word[17];

  // ---------------- geometry measurement ----------------
  logic [CNT_W-1:0] pix_cnt_q, line_len_q, line_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt_q  <= '0;
      line_len_q <= '0;
      line_cnt_q <= '0;
      width      <= '0;
      height     <= '0;
      locked     <= 1'b0;
    end else begin
      if (de_in_q) begin
        if (pix_cnt_q != CNT_MAX) pix_cnt_q <= pix_cnt_q + 1'b1;
      end else if (de_fall) begin
        line_len_q <= pix_cnt_q;
        pix_cnt_q  <= '0;
      end

      if (vs_edge) begin
        line_cnt_q <= '0;
        width      <= line_len_q;
        height     <= line_cnt_q;
        // Compare the new capture with the previous one still held in width/height.
        locked     <= (line_len_q == width) && (line_cnt_q == height) &&
                      (line_len_q != '0) && (line_cnt_q != '0);
      end else if (de_fall && (line_cnt_q != CNT_MAX)) begin
        line_cnt_q <= line_cnt_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_rx_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_rx_capture
// Purpose  : Frame-level directed vectors for hdmi_rx_capture. Two instances
//            run in lockstep: one with active-high syncs, one with active-low
//            syncs driven by inverted pins; both must produce the same stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_rx_capture;

  logic        clk = 1'b0;
  logic        reset, enable, de, hs, vs, tready;
  logic [15:0] data;
  logic        hs_n, vs_n;
  int          tr_mode;   // 0: tready=1, 1: tready=0, 2: toggle each cycle
  int          vec_cnt = 0;
  int          err_cnt = 0;

  logic [15:0] t0_data, t1_data;
  logic        t0_valid, t1_valid, t0_user, t1_user, t0_last, t1_last;
  logic [11:0] w0, w1, h0, h1;
  logic        lk0, lk1, ov0, ov1;

  assign hs_n = ~hs;
  assign vs_n = ~vs;

  always #5 clk = ~clk;

  hdmi_rx_capture #(.FIFO_DEPTH(16), .HS_POL(1), .VS_POL(1), .CNT_W(12)) u_dut (
    .clk(clk), .reset(reset), .enable(enable),
    .hdmi_data(data), .hdmi_data_e(de), .hdmi_hsync(hs), .hdmi_vsync(vs),
    .m_axis_tdata(t0_data), .m_axis_tvalid(t0_valid), .m_axis_tready(tready),
    .m_axis_tuser(t0_user), .m_axis_tlast(t0_last),
    .width(w0), .height(h0), .locked(lk0), .overflow(ov0));

  hdmi_rx_capture #(.FIFO_DEPTH(16), .HS_POL(0), .VS_POL(0), .CNT_W(12)) u_dut_n (
    .clk(clk), .reset(reset), .enable(enable),
    .hdmi_data(data), .hdmi_data_e(de), .hdmi_hsync(hs_n), .hdmi_vsync(vs_n),
    .m_axis_tdata(t1_data), .m_axis_tvalid(t1_valid), .m_axis_tready(tready),
    .m_axis_tuser(t1_user), .m_axis_tlast(t1_last),
    .width(w1), .height(h1), .locked(lk1), .overflow(ov1));

  // ---------------- tready pattern ----------------
  always begin
    @(posedge clk);
    #1;
    case (tr_mode)
      0:       tready = 1'b1;
      1:       tready = 1'b0;
      default: tready = ~tready;
    endcase
  end

  // ---------------- stream monitor ----------------
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic        stall0 = 1'b0, stall1 = 1'b0;
  logic [17:0] held0, held1;

  always @(negedge clk) begin
    if (stall0 && t0_valid) begin
      vec_cnt++;
      if ({t0_user, t0_last, t0_data} != held0) begin
        err_cnt++;
        $display("FAIL stall_hold dut0: got %h expected %h", {t0_user, t0_last, t0_data}, held0);
      end
    end
    if (stall1 && t1_valid) begin
      vec_cnt++;
      if ({t1_user, t1_last, t1_data} != held1) begin
        err_cnt++;
        $display("FAIL stall_hold dut1: got %h expected %h", {t1_user, t1_last, t1_data}, held1);
      end
    end
    stall0 = t0_valid && !tready;
    stall1 = t1_valid && !tready;
    held0  = {t0_user, t0_last, t0_data};
    held1  = {t1_user, t1_last, t1_data};
    if (t0_valid && tready) q0.push_back({t0_user, t0_last, t0_data});
    if (t1_valid && tready) q1.push_back({t1_user, t1_last, t1_data});
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_vsync();
    vs = 1'b1;
    repeat (3) tick();
    vs = 1'b0;
    repeat (5) tick();
  endtask

  task automatic do_lines(input int w, input int h, input int fid, input bit en_mid);
    for (int l = 0; l < h; l++) begin
      if (en_mid && l == 1) enable = 1'b1;
      hs = 1'b1;
      repeat (2) tick();
      hs = 1'b0;
      repeat (4) tick();
      for (int p = 0; p < w; p++) begin
        de   = 1'b1;
        data = {4'(fid), 4'(l), 8'(p)};
        tick();
      end
      de   = 1'b0;
      data = 16'h0;
      repeat (12) tick();
    end
  endtask

  task automatic drain();
    int t;
    tr_mode = 0;
    t = 0;
    while ((t0_valid || t1_valid) && t < 300) begin
      tick();
      t++;
    end
    chk("drain_timeout", int'(t0_valid | t1_valid), 0);
    repeat (2) tick();
  endtask

  task automatic check_q(input int di, input int n, input int w, input int fid);
    int          sz;
    bit          bad;
    logic [17:0] b, e;
    sz  = (di == 0) ? q0.size() : q1.size();
    chk($sformatf("beat_count dut%0d frame%0d", di, fid), sz, n);
    bad = 1'b0;
    for (int k = 0; k < sz && k < n; k++) begin
      b = (di == 0) ? q0[k] : q1[k];
      e = {(k == 0), ((k % w) == w - 1), 4'(fid), 4'(k / w), 8'(k % w)};
      if (b != e && !bad) begin
        bad = 1'b1;
        $display("FAIL beat_data dut%0d frame%0d beat %0d: got %h expected %h", di, fid, k, b, e);
      end
    end
    vec_cnt++;
    if (bad) err_cnt++;
  endtask

  typedef struct {
    int w; int h; bit en_vs; bit en_mid; int tr;
    int beats; int exp_w; int exp_h; bit exp_lk; bit exp_ov;
  } vec_t;

  task automatic run_vec(input vec_t v, input int fid);
    q0.delete();
    q1.delete();
    tr_mode = v.tr;
    enable  = v.en_vs;
    do_vsync();
    chk($sformatf("width dut0 frame%0d", fid),  int'(w0),  v.exp_w);
    chk($sformatf("height dut0 frame%0d", fid), int'(h0),  v.exp_h);
    chk($sformatf("locked dut0 frame%0d", fid), int'(lk0), int'(v.exp_lk));
    chk($sformatf("width dut1 frame%0d", fid),  int'(w1),  v.exp_w);
    chk($sformatf("height dut1 frame%0d", fid), int'(h1),  v.exp_h);
    chk($sformatf("locked dut1 frame%0d", fid), int'(lk1), int'(v.exp_lk));
    do_lines(v.w, v.h, fid, v.en_mid);
    drain();
    check_q(0, v.beats, v.w, fid);
    check_q(1, v.beats, v.w, fid);
    chk($sformatf("overflow dut0 frame%0d", fid), int'(ov0), int'(v.exp_ov));
    chk($sformatf("overflow dut1 frame%0d", fid), int'(ov1), int'(v.exp_ov));
  endtask

  vec_t vecs[12];

  initial begin
    //            w  h en mid tr beats  w  h lk ov
    vecs[0]  = '{8, 4, 1, 0, 0, 32, 0, 0, 0, 0};  // first frame, no geometry yet
    vecs[1]  = '{8, 4, 1, 0, 0, 32, 8, 4, 0, 0};  // first real capture
    vecs[2]  = '{8, 4, 1, 0, 0, 32, 8, 4, 1, 0};  // second equal capture locks
    vecs[3]  = '{8, 4, 0, 1, 0,  0, 8, 4, 1, 0};  // disabled at vsync, raised mid-frame
    vecs[4]  = '{8, 4, 1, 0, 0, 32, 8, 4, 1, 0};  // complete frame after enable
    vecs[5]  = '{8, 4, 1, 0, 1, 16, 8, 4, 1, 1};  // stalled sink: 16 kept, rest dropped
    vecs[6]  = '{8, 4, 1, 0, 0, 32, 8, 4, 1, 1};  // clean frame, overflow stays sticky
    vecs[7]  = '{8, 4, 1, 0, 2, 32, 8, 4, 1, 1};  // ready toggling every cycle
    vecs[8]  = '{10, 4, 1, 0, 0, 40, 8, 4, 1, 1}; // alternating widths begin
    vecs[9]  = '{8, 4, 1, 0, 0, 32, 10, 4, 0, 1};
    vecs[10] = '{10, 4, 1, 0, 0, 40, 8, 4, 0, 1};
    vecs[11] = '{8, 4, 1, 0, 0, 32, 10, 4, 0, 1};

    reset = 1'b1; enable = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0;
    data = 16'h0; tr_mode = 0; tready = 1'b1;
    repeat (3) tick();
    chk("reset tvalid dut0",   int'(t0_valid), 0);
    chk("reset tvalid dut1",   int'(t1_valid), 0);
    chk("reset tdata dut0",    int'(t0_data),  0);
    chk("reset tuser/tlast",   int'({t0_user, t0_last, t1_user, t1_last}), 0);
    chk("reset width/height",  int'({w0, h0}), 0);
    chk("reset locked/ovf",    int'({lk0, ov0, lk1, ov1}), 0);
    reset = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset in the middle of a line while the FIFO holds data.
    tr_mode = 1;
    enable  = 1'b1;
    do_vsync();
    for (int p = 0; p < 5; p++) begin
      de   = 1'b1;
      data = {4'd12, 4'd0, 8'(p)};
      tick();
    end
    chk("pre_reset tvalid", int'(t0_valid & t1_valid), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset tvalid dut0", int'(t0_valid), 0);
    chk("mid_reset tvalid dut1", int'(t1_valid), 0);
    chk("mid_reset overflow",    int'({ov0, ov1}), 0);
    chk("mid_reset geometry",    int'({w0, h0, lk0}), 0);
    tick();
    de   = 1'b0;
    data = 16'h0;
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // Without a vsync edge the block must stay in SEARCH and write nothing.
    q0.delete();
    q1.delete();
    tr_mode = 0;
    do_lines(8, 1, 12, 1'b0);
    drain();
    chk("search_no_beats dut0", q0.size(), 0);
    chk("search_no_beats dut1", q1.size(), 0);

    run_vec('{8, 4, 1, 0, 0, 32, 8, 1, 0, 0}, 13);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", err_cnt);
    $fatal(1);
  end

endmodule
`default_nettype wire
